sdram_arbiter: RTL

- Shares the single SDRAM read/write port among NUM_REQ requesters, e.g. record core, playback core and mix core.
- Each requester uses the same level-request / finished-pulse protocol it would use on a dedicated SDRAM port.
- Round-robin arbitration; one transaction in flight at a time; the grant is held until the SDRAM controller reports completion.
- Sits between the cores and the SDRAM controller in the top level.

---
 rtl/sdram_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM read/write port among NUM_REQ requesters.
// One transaction in flight; grant held until the controller reports completion.
module sdram_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int AW      = 23,
  parameter int DW      = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_REQ-1:0]    req_read,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_writedata,
  output logic [DW-1:0]         req_readdata,
  output logic [NUM_REQ-1:0]    req_finished,
  output logic                  sdram_read,
  output logic                  sdram_write,
  output logic [AW-1:0]         sdram_addr,
  output logic [DW-1:0]         sdram_writedata,
  input  logic [DW-1:0]         sdram_readdata,
  input  logic                  sdram_finished,
  output logic [2:0]            grant_idx,
  output logic                  busy
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RELEASE} state_t;

  state_t               r_state;
  logic [2:0]           r_last;
  logic [2:0]           r_grant;
  logic                 r_busy;
  logic                 r_sdram_read;
  logic                 r_sdram_write;
  logic [AW-1:0]        r_sdram_addr;
  logic [DW-1:0]        r_sdram_writedata;
  logic [DW-1:0]        r_readdata;
  logic [NUM_REQ-1:0]   r_finished;

  logic [7:0] w_pend8;
  logic [7:0] w_rd8;
  logic [7:0] w_wr8;
  logic       w_any;
  logic [2:0] w_sel;
  logic [2:0] w_cand;

  // Widen to 8 bits so a 3-bit index is always in range for any NUM_REQ.
  assign w_rd8   = 8'(req_read);
  assign w_wr8   = 8'(req_write);
  assign w_pend8 = w_rd8 | w_wr8;

  // Scan from farthest to nearest so the nearest pending index after r_last wins.
  always_comb begin
    w_any  = 1'b0;
    w_sel  = r_last;
    w_cand = 3'd0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_cand = 3'((int'(r_last) + k) % NUM_REQ);
      if (w_pend8[w_cand]) begin
        w_any = 1'b1;
        w_sel = w_cand;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state           <= S_IDLE;
      r_last            <= 3'(NUM_REQ - 1);
      r_grant           <= 3'd0;
      r_busy            <= 1'b0;
      r_sdram_read      <= 1'b0;
      r_sdram_write     <= 1'b0;
      r_sdram_addr      <= '0;
      r_sdram_writedata <= '0;
      r_readdata        <= '0;
      r_finished        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_sdram_write     <= w_wr8[w_sel];
            r_sdram_read      <= w_rd8[w_sel] & ~w_wr8[w_sel];
            r_sdram_addr      <= req_addr[int'(w_sel)*AW +: AW];
            r_sdram_writedata <= req_writedata[int'(w_sel)*DW +: DW];
            r_grant           <= w_sel;
            r_last            <= w_sel;
            r_busy            <= 1'b1;
            r_state           <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (sdram_finished) begin
            r_sdram_read  <= 1'b0;
            r_sdram_write <= 1'b0;
            r_finished    <= NUM_REQ'(1) << r_grant;
            if (!r_sdram_write) r_readdata <= sdram_readdata;
            r_state       <= S_RELEASE;
          end
        end
        // One dead cycle lets the finished requester drop its level before re-arbitration.
        S_RELEASE: begin
          r_finished <= '0;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_readdata    = r_readdata;
  assign req_finished    = r_finished;
  assign sdram_read      = r_sdram_read;
  assign sdram_write     = r_sdram_write;
  assign sdram_addr      = r_sdram_addr;
  assign sdram_writedata = r_sdram_writedata;
  assign grant_idx       = r_grant;
  assign busy            = r_busy;

endmodule
